sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter: ROWW, default 4, number of row address bits stored (RA[ROWW-1:0]).
REQ-002 Parameter: COLW, default 4, number of column address bits stored (RA[COLW-1:0]).
REQ-003 Port: C8M  in  1  clock; all state updates on its rising edge; SDRAM pins sampled on that edge.
REQ-004 Port: RESET  in  1  synchronous, active-high reset.
REQ-005 Ports: nCS, nRAS, nCAS, nRWE, CKE  in  1 each  SDRAM command pins.
REQ-006 Ports: RBA  in  2  bank address; RA  in  13  row/column/mode address.
REQ-007 Ports: DQMH, DQML  in  1 each  active-low byte-lane enables (high lane / low lane).
REQ-008 Ports: RD_IN  in  8  data from controller; RD_OUT  out  8  read data; RD_OE  out  1  responder drives data bus.
REQ-009 Ports: MODE  out  13  last loaded mode register; READY  out  1  init complete; ERR  out  1  sticky error; ERRCODE  out  3  first error code; REFCNT  out  16  auto-refresh count.

Function
REQ-010 Commands decoded only when CKE=1 and nCS=0; {nRAS,nCAS,nRWE}: 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 AREF, 000 LMR, 111 NOP; CKE=0 -> no decode, read pipeline frozen.
REQ-011 Init FSM: POWERUP -(PRE with RA[10]=1)-> PRECHARGED -(LMR)-> READY; any other non-NOP command in POWERUP/PRECHARGED -> error code 1, FSM unchanged; READY output =1 only in READY.
REQ-012 LMR: MODE <= RA, accepted in PRECHARGED or in READY with all banks closed; otherwise error 2, MODE unchanged.
REQ-013 Supported mode: RA[6:4] in {2,3} (CAS latency), RA[2:0]=0 (burst 1); unsupported value -> error 3, MODE still loaded, READ data timed with CL=2.
REQ-014 Per-bank state: open flag + open row (RA[ROWW-1:0]); ACT opens bank RBA; ACT to open bank -> error 4, row replaced.
REQ-015 PRE: RA[10]=1 closes all banks, else closes bank RBA; PRE of closed bank is legal, no error.
REQ-016 Storage: 2^(2+ROWW+COLW) words of 16 bits, address {RBA, open row, RA[COLW-1:0]}; upper row/column bits ignored (aliasing).
REQ-017 WRITE: RD_IN sampled on same edge as command; DQML=0 -> low byte written, DQMH=0 -> high byte written, both high -> no write.
REQ-018 READ: lane selected at command edge (DQML=0 -> low byte, else DQMH=0 -> high byte, else masked); data registered into CL-deep pipeline.
REQ-019 READ sampled at edge k: RD_OE=1 and RD_OUT valid for exactly one cycle, edges k+CL-1 to k+CL; masked read -> RD_OE stays 0; back-to-back READs stream one per cycle.
REQ-020 RD_OE=0 -> RD_OUT=0.
REQ-021 READ/WRITE with RA[10]=1 (auto-precharge) closes the bank after the access, same edge.
REQ-022 READ/WRITE to closed bank -> error 5, no storage change, no read data.
REQ-023 AREF: REFCNT+1, saturating at 16'hFFFF; AREF with any bank open -> error 6, still counted.
REQ-024 WRITE sampled while RD_OE=1 -> error 7 (bus conflict); write still performed, read data still output.
REQ-025 ERR sticky until RESET; ERRCODE holds first error code; simultaneous conditions on one command -> lowest code recorded.

Reset
REQ-026 RESET=1 at edge: FSM POWERUP, all banks closed, MODE=0, read pipeline cleared, RD_OE=0, RD_OUT=0, READY=0, ERR=0, ERRCODE=0, REFCNT=0; storage contents not reset.
REQ-027 RESET mid-read: pending data discarded, RD_OE=0 from next cycle.
REQ-028 Commands sampled on the same edge as RESET=1 are ignored.

Verification
REQ-029 Init: PRE RA=0x400, LMR RA=0x220 -> READY=1, MODE=0x220, ERR=0.
REQ-030 Write/read CL2: ACT bank1 row3; WRITE col5 RD_IN=0xA5 DQML=0 DQMH=1; READ col5 DQML=0 at edge k -> RD_OE=1 and RD_OUT=0xA5 edge k+1..k+2 only.
REQ-031 Byte lanes: WRITE 0x3C high lane, 0xC3 low lane same column; READ high -> 0x3C, READ low -> 0xC3; READ with DQMH=DQML=1 -> RD_OE stays 0.
REQ-032 Errors: READ before any ACT in READY -> ERR=1, ERRCODE=5; later ACT twice same bank -> ERRCODE stays 5.
REQ-033 Refresh: 3 AREF with banks closed -> REFCNT=3, ERR=0; CL3 mode: READ at edge k -> data at edge k+3.
REQ-034 Reset mid-read: READ at edge k, RESET at edge k+1 -> RD_OE=0 throughout, READY=0, REFCNT=0.

Source files
------------

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device model: decodes controller commands, tracks init and
// bank state, stores data per byte lane, and returns reads after the CAS latency.
module sdram_responder #(
  parameter int ROWW = 4,
  parameter int COLW = 4
) (
  input  logic        C8M,
  input  logic        RESET,
  input  logic        nCS,
  input  logic        nRAS,
  input  logic        nCAS,
  input  logic        nRWE,
  input  logic        CKE,
  input  logic [1:0]  RBA,
  input  logic [12:0] RA,
  input  logic        DQMH,
  input  logic        DQML,
  input  logic [7:0]  RD_IN,
  output logic [7:0]  RD_OUT,
  output logic        RD_OE,
  output logic [12:0] MODE,
  output logic        READY,
  output logic        ERR,
  output logic [2:0]  ERRCODE,
  output logic [15:0] REFCNT
);

  localparam int AW = 2 + ROWW + COLW;

  typedef enum logic [1:0] {ST_POWERUP, ST_PRECHARGED, ST_READY} init_state_t;

  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_AREF  = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_t;

  init_state_t     state;
  logic [3:0]      bank_open;
  logic [ROWW-1:0] bank_row [4];
  logic [15:0]     mem [2**AW];

  // Read pipeline: CL3 reads enter at p0, CL2 reads enter at p1; RD_OE/RD_OUT is the last stage.
  logic            p0_v, p1_v;
  logic [7:0]      p0_d, p1_d;

  logic            cmd_en;
  cmd_t            cmd;
  logic [AW-1:0]   addr;
  logic            hit;
  logic            mode_ok;
  logic            cl3;
  logic            wr_fire;
  logic            rd_fire;
  logic [7:0]      rd_byte;
  logic [2:0]      err_code;

  assign cmd_en  = CKE & ~nCS;
  assign cmd     = cmd_t'({nRAS, nCAS, nRWE});
  assign addr    = {RBA, bank_row[RBA], RA[COLW-1:0]};
  assign hit     = bank_open[RBA];
  assign mode_ok = (RA[6:4] == 3'd2 || RA[6:4] == 3'd3) && RA[2:0] == 3'd0;
  assign cl3     = MODE[6:4] == 3'd3 && MODE[2:0] == 3'd0;
  assign wr_fire = cmd_en && state == ST_READY && cmd == CMD_WRITE && hit;
  assign rd_fire = cmd_en && state == ST_READY && cmd == CMD_READ && hit && !(DQML && DQMH);
  assign rd_byte = !DQML ? mem[addr][7:0] : mem[addr][15:8];

  // Lowest applicable code wins when one command trips several checks.
  // NOTE: err_code is defaulted first so every path assigns it and no latch is inferred.
  always_comb begin
    err_code = 3'd0;
    if (cmd_en) begin
      case (state)
        ST_POWERUP: begin
          if (cmd != CMD_NOP && cmd != CMD_BST && !(cmd == CMD_PRE && RA[10]))
            err_code = 3'd1;
        end
        ST_PRECHARGED: begin
          if (cmd == CMD_LMR) begin
            if (!mode_ok) err_code = 3'd3;
          end else if (cmd != CMD_NOP && cmd != CMD_BST) begin
            err_code = 3'd1;
          end
        end
        default: begin
          case (cmd)
            CMD_LMR:   if (|bank_open) err_code = 3'd2;
                       else if (!mode_ok) err_code = 3'd3;
            CMD_ACT:   if (hit) err_code = 3'd4;
            CMD_READ:  if (!hit) err_code = 3'd5;
            CMD_WRITE: if (!hit) err_code = 3'd5;
                       else if (RD_OE) err_code = 3'd7;
            CMD_AREF:  if (|bank_open) err_code = 3'd6;
            default:   ;
          endcase
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every read above sees pre-edge values.
  always_ff @(posedge C8M) begin
    if (RESET) begin
      state     <= ST_POWERUP;
      bank_open <= '0;
      for (int i = 0; i < 4; i++) bank_row[i] <= '0;
      MODE      <= '0;
      p0_v      <= 1'b0;
      p0_d      <= '0;
      p1_v      <= 1'b0;
      p1_d      <= '0;
      RD_OE     <= 1'b0;
      RD_OUT    <= '0;
      READY     <= 1'b0;
      ERR       <= 1'b0;
      ERRCODE   <= '0;
      REFCNT    <= '0;
    end else begin
      if (err_code != 3'd0 && !ERR) begin
        ERR     <= 1'b1;
        ERRCODE <= err_code;
      end

      if (CKE) begin
        p0_v   <= 1'b0;
        p1_v   <= p0_v;
        p1_d   <= p0_d;
        RD_OE  <= p1_v;
        RD_OUT <= p1_v ? p1_d : 8'h00;
        if (rd_fire) begin
          if (cl3) begin
            p0_v <= 1'b1;
            p0_d <= rd_byte;
          end else begin
            p1_v <= 1'b1;
            p1_d <= rd_byte;
          end
        end
      end

      if (cmd_en) begin
        case (state)
          ST_POWERUP: begin
            if (cmd == CMD_PRE && RA[10]) state <= ST_PRECHARGED;
          end
          ST_PRECHARGED: begin
            if (cmd == CMD_LMR) begin
              MODE  <= RA;
              state <= ST_READY;
              READY <= 1'b1;
            end
          end
          default: begin
            case (cmd)
              CMD_LMR: if (bank_open == 4'b0000) MODE <= RA;
              CMD_ACT: begin
                bank_open[RBA] <= 1'b1;
                bank_row[RBA]  <= RA[ROWW-1:0];
              end
              CMD_PRE: if (RA[10]) bank_open <= '0;
                       else bank_open[RBA] <= 1'b0;
              CMD_READ, CMD_WRITE: if (hit && RA[10]) bank_open[RBA] <= 1'b0;
              CMD_AREF: if (REFCNT != 16'hFFFF) REFCNT <= REFCNT + 16'd1;
              default: ;
            endcase
          end
        endcase
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; contents survive RESET like a real device.
  always_ff @(posedge C8M) begin
    if (!RESET && wr_fire) begin
      if (!DQML) mem[addr][7:0]  <= RD_IN;
      if (!DQMH) mem[addr][15:8] <= RD_IN;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed scenarios plus random command
// streams, all compared every cycle against a command-level reference model.
module tb_sdram_responder;

  localparam int ROWW = 4;
  localparam int COLW = 4;
  localparam int WORDS = 1 << (2 + ROWW + COLW);

  localparam logic [2:0] C_LMR = 3'b000, C_AREF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WRITE = 3'b100, C_READ = 3'b101, C_NOP = 3'b111;

  logic        C8M = 1'b0;
  logic        RESET, nCS, nRAS, nCAS, nRWE, CKE;
  logic [1:0]  RBA;
  logic [12:0] RA;
  logic        DQMH, DQML;
  logic [7:0]  RD_IN, RD_OUT;
  logic        RD_OE;
  logic [12:0] MODE;
  logic        READY, ERR;
  logic [2:0]  ERRCODE;
  logic [15:0] REFCNT;

  int n_checks = 0;
  int n_errors = 0;

  sdram_responder #(.ROWW(ROWW), .COLW(COLW)) dut (
    .C8M(C8M), .RESET(RESET), .nCS(nCS), .nRAS(nRAS), .nCAS(nCAS), .nRWE(nRWE),
    .CKE(CKE), .RBA(RBA), .RA(RA), .DQMH(DQMH), .DQML(DQML), .RD_IN(RD_IN),
    .RD_OUT(RD_OUT), .RD_OE(RD_OE), .MODE(MODE), .READY(READY), .ERR(ERR),
    .ERRCODE(ERRCODE), .REFCNT(REFCNT)
  );

  always #5 C8M = ~C8M;

  // Reference model: device state plus a schedule of bus outputs indexed by
  // the count of clock-enabled edges since reset.
  int          m_state;
  bit          m_open [4];
  int          m_row [4];
  logic [12:0] m_mode;
  bit          m_err;
  int          m_code;
  int          m_ref;
  bit [15:0]   m_mem [WORDS];
  bit          m_lo_known [WORDS];
  bit          m_hi_known [WORDS];
  int          t;
  bit          s_v [128];
  bit          s_k [128];
  bit [7:0]    s_d [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mode_supported(input logic [12:0] m);
    return (m[6:4] == 3'd2 || m[6:4] == 3'd3) && m[2:0] == 3'd0;
  endfunction

  task automatic model_edge();
    logic [2:0] cmd;
    bit any_open, oe_before;
    int code, a, cl, slot;
    if (RESET) begin
      m_state = 0; m_mode = '0; m_err = 0; m_code = 0; m_ref = 0; t = 0;
      for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_row[i] = 0; end
      for (int i = 0; i < 128; i++) s_v[i] = 0;
      return;
    end
    oe_before = s_v[t % 128];
    if (CKE) begin
      s_v[t % 128] = 0;
      t++;
    end
    if (!(CKE && !nCS)) return;
    cmd = {nRAS, nCAS, nRWE};
    code = 0;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    a = int'(RBA) * (1 << (ROWW + COLW)) + m_row[RBA] * (1 << COLW) + int'(RA) % (1 << COLW);
    if (m_state == 0) begin
      if (cmd == C_PRE && RA[10]) m_state = 1;
      else if (cmd != C_NOP) code = 1;
    end else if (m_state == 1) begin
      if (cmd == C_LMR) begin
        m_mode = RA; m_state = 2;
        if (!mode_supported(RA)) code = 3;
      end else if (cmd != C_NOP) code = 1;
    end else begin
      case (cmd)
        C_LMR: if (any_open) code = 2;
               else begin m_mode = RA; if (!mode_supported(RA)) code = 3; end
        C_ACT: begin
          if (m_open[RBA]) code = 4;
          m_open[RBA] = 1; m_row[RBA] = int'(RA) % (1 << ROWW);
        end
        C_PRE: if (RA[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
               else m_open[RBA] = 0;
        C_AREF: begin
          if (any_open) code = 6;
          if (m_ref < 65535) m_ref++;
        end
        C_WRITE: if (!m_open[RBA]) code = 5;
          else begin
            if (oe_before) code = 7;
            if (!DQML) begin m_mem[a][7:0] = RD_IN; m_lo_known[a] = 1; end
            if (!DQMH) begin m_mem[a][15:8] = RD_IN; m_hi_known[a] = 1; end
            if (RA[10]) m_open[RBA] = 0;
          end
        C_READ: if (!m_open[RBA]) code = 5;
          else begin
            cl = (mode_supported(m_mode) && m_mode[6:4] == 3'd3) ? 3 : 2;
            slot = (t + cl - 1) % 128;
            if (!DQML) begin s_v[slot] = 1; s_d[slot] = m_mem[a][7:0]; s_k[slot] = m_lo_known[a]; end
            else if (!DQMH) begin s_v[slot] = 1; s_d[slot] = m_mem[a][15:8]; s_k[slot] = m_hi_known[a]; end
            if (RA[10]) m_open[RBA] = 0;
          end
        default: ;
      endcase
    end
    if (code != 0 && !m_err) begin m_err = 1; m_code = code; end
  endtask

  task automatic compare_all();
    int s;
    s = t % 128;
    check("ready", READY, m_state == 2);
    check("rd_oe", RD_OE, s_v[s]);
    if (!s_v[s]) check("rd_out_idle", RD_OUT, 8'h00);
    else if (s_k[s]) check("rd_out", RD_OUT, s_d[s]);
    check("err", ERR, m_err);
    check("errcode", ERRCODE, m_code);
    check("refcnt", REFCNT, m_ref);
    check("mode", MODE, m_mode);
  endtask

  task automatic tick();
    @(posedge C8M);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    nCS = 1'b1; {nRAS, nCAS, nRWE} = C_NOP; RBA = '0; RA = '0;
    DQMH = 1'b1; DQML = 1'b1; RD_IN = '0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic dh, input logic dl, input logic [7:0] d);
    nCS = 1'b0; {nRAS, nCAS, nRWE} = c; RBA = ba; RA = a; DQMH = dh; DQML = dl; RD_IN = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
  endtask

  task automatic init(input logic [12:0] m);
    issue(C_PRE, 2'd0, 13'h400, 1'b1, 1'b1, 8'h00);
    issue(C_LMR, 2'd0, m, 1'b1, 1'b1, 8'h00);
  endtask

  function automatic logic [12:0] pick_mode(input int i);
    case (i)
      0: return 13'h020;
      1: return 13'h030;
      2: return 13'h230;
      default: return 13'h031;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [2:0] c;
    logic [12:0] a;
    RESET = 1'b1; CKE = 1'b1; idle();
    tick(); tick();
    check("rst_ready", READY, 0);
    check("rst_oe", RD_OE, 0);
    check("rst_mode", MODE, 0);
    check("rst_refcnt", REFCNT, 0);
    check("rst_err", {ERR, ERRCODE}, 0);
    RESET = 1'b0;

    init(13'h220);
    check("init_ready", READY, 1);
    check("init_mode", MODE, 13'h220);
    check("init_err", ERR, 0);

    // CL2 write then read
    issue(C_ACT, 2'd1, 13'd3, 1'b1, 1'b1, 8'h00);
    issue(C_WRITE, 2'd1, 13'd5, 1'b1, 1'b0, 8'hA5);
    issue(C_READ, 2'd1, 13'd5, 1'b1, 1'b0, 8'h00);
    check("cl2_k_oe", RD_OE, 0);
    tick(); check("cl2_k1_oe", RD_OE, 1); check("cl2_k1_data", RD_OUT, 8'hA5);
    tick(); check("cl2_k2_oe", RD_OE, 0); check("cl2_k2_data", RD_OUT, 8'h00);

    // Byte lanes, streamed reads and a masked read
    issue(C_WRITE, 2'd1, 13'd6, 1'b0, 1'b1, 8'h3C);
    issue(C_WRITE, 2'd1, 13'd6, 1'b1, 1'b0, 8'hC3);
    issue(C_READ, 2'd1, 13'd6, 1'b0, 1'b1, 8'h00);
    issue(C_READ, 2'd1, 13'd6, 1'b1, 1'b0, 8'h00);
    check("lane_hi_oe", RD_OE, 1); check("lane_hi", RD_OUT, 8'h3C);
    issue(C_READ, 2'd1, 13'd6, 1'b1, 1'b1, 8'h00);
    check("lane_lo", RD_OUT, 8'hC3);
    tick(); check("lane_masked_oe", RD_OE, 0);

    // Refresh with banks closed, then CL3
    issue(C_PRE, 2'd0, 13'h400, 1'b1, 1'b1, 8'h00);
    repeat (3) issue(C_AREF, 2'd0, 13'h000, 1'b1, 1'b1, 8'h00);
    check("aref_cnt", REFCNT, 3);
    check("aref_err", ERR, 0);
    issue(C_LMR, 2'd0, 13'h230, 1'b1, 1'b1, 8'h00);
    check("cl3_mode", MODE, 13'h230);
    issue(C_ACT, 2'd1, 13'd3, 1'b1, 1'b1, 8'h00);
    issue(C_READ, 2'd1, 13'd5, 1'b1, 1'b0, 8'h00);
    tick(); check("cl3_k1_oe", RD_OE, 0);
    tick(); check("cl3_k2_oe", RD_OE, 1); check("cl3_k2_data", RD_OUT, 8'hA5);
    tick(); check("cl3_k3_oe", RD_OE, 0);

    // Clock-enable low freezes the read pipeline and holds the bus
    issue(C_READ, 2'd1, 13'd5, 1'b1, 1'b0, 8'h00);
    CKE = 1'b0; tick(); tick(); check("frz_oe0", RD_OE, 0);
    CKE = 1'b1; tick(); check("frz_k1_oe", RD_OE, 0);
    tick(); check("frz_k2_oe", RD_OE, 1);
    CKE = 1'b0; tick(); check("frz_hold_oe", RD_OE, 1); check("frz_hold_data", RD_OUT, 8'hA5);
    CKE = 1'b1; tick(); check("frz_end_oe", RD_OE, 0);

    // READ to closed bank, then a double ACT keeps the first code
    do_reset(); init(13'h220);
    issue(C_READ, 2'd0, 13'd0, 1'b1, 1'b0, 8'h00);
    check("e5_err", ERR, 1); check("e5_code", ERRCODE, 5);
    issue(C_ACT, 2'd2, 13'd1, 1'b1, 1'b1, 8'h00);
    issue(C_ACT, 2'd2, 13'd2, 1'b1, 1'b1, 8'h00);
    check("e5_sticky", ERRCODE, 5);

    // Command before init
    do_reset();
    issue(C_ACT, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    check("e1_code", ERRCODE, 1); check("e1_ready", READY, 0);

    // Unsupported mode: loaded, error 3, CL2 timing
    do_reset(); init(13'h221);
    check("e3_ready", READY, 1); check("e3_code", ERRCODE, 3); check("e3_mode", MODE, 13'h221);
    issue(C_ACT, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_WRITE, 2'd0, 13'd1, 1'b1, 1'b0, 8'h5A);
    issue(C_READ, 2'd0, 13'd1, 1'b1, 1'b0, 8'h00);
    tick(); check("e3_cl2_data", RD_OUT, 8'h5A);

    // Bus conflict: write performed, storage survives reset
    do_reset(); init(13'h220);
    issue(C_ACT, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_READ, 2'd0, 13'd1, 1'b1, 1'b0, 8'h00);
    tick(); check("keep_data", RD_OUT, 8'h5A);
    issue(C_WRITE, 2'd0, 13'd2, 1'b1, 1'b0, 8'h77);
    check("e7_code", ERRCODE, 7);
    issue(C_READ, 2'd0, 13'd2, 1'b1, 1'b0, 8'h00);
    tick(); check("e7_written", RD_OUT, 8'h77);

    // Closed bank beats bus conflict
    do_reset(); init(13'h220);
    issue(C_ACT, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_READ, 2'd0, 13'h401, 1'b1, 1'b0, 8'h00);
    tick();
    issue(C_WRITE, 2'd0, 13'd2, 1'b1, 1'b0, 8'h11);
    check("e5_over_e7", ERRCODE, 5);

    // LMR with open bank, double ACT, AREF with open bank
    do_reset(); init(13'h220);
    issue(C_ACT, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_LMR, 2'd0, 13'h230, 1'b1, 1'b1, 8'h00);
    check("e2_code", ERRCODE, 2); check("e2_mode", MODE, 13'h220);
    do_reset(); init(13'h220);
    issue(C_ACT, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_ACT, 2'd0, 13'd1, 1'b1, 1'b1, 8'h00);
    check("e4_code", ERRCODE, 4);
    do_reset(); init(13'h220);
    issue(C_ACT, 2'd3, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_AREF, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    check("e6_code", ERRCODE, 6); check("e6_refcnt", REFCNT, 1);

    // Reset during a read; command on the reset edge is ignored
    do_reset(); init(13'h220);
    issue(C_AREF, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_ACT, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    issue(C_READ, 2'd0, 13'd1, 1'b1, 1'b0, 8'h00);
    check("rr_k_oe", RD_OE, 0);
    RESET = 1'b1;
    issue(C_AREF, 2'd0, 13'd0, 1'b1, 1'b1, 8'h00);
    check("rr_k1_oe", RD_OE, 0); check("rr_ready", READY, 0); check("rr_refcnt", REFCNT, 0);
    tick(); RESET = 1'b0;
    tick(); check("rr_k3_oe", RD_OE, 0);

    // Random command streams
    for (int seg = 0; seg < 10; seg++) begin
      do_reset();
      init(pick_mode($urandom_range(0, 5) == 0 ? 3 : $urandom_range(0, 2)));
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 99);
        a = 13'($urandom);
        if (r < 20)      c = C_ACT;
        else if (r < 45) c = C_READ;
        else if (r < 70) c = C_WRITE;
        else if (r < 80) c = C_PRE;
        else if (r < 84) c = C_AREF;
        else if (r < 86) c = C_LMR;
        else             c = C_NOP;
        if (c == C_READ || c == C_WRITE) a[10] = ($urandom_range(0, 7) == 0);
        if (c == C_PRE) a[10] = ($urandom_range(0, 2) == 0);
        if (c == C_LMR) a = pick_mode($urandom_range(0, 3));
        if (r >= 93) CKE = 1'b0;
        if (c == C_NOP && r < 93) tick();
        else issue(c, 2'($urandom), a, 1'($urandom), 1'($urandom), 8'($urandom));
        CKE = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
